muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide engine beside the execute-stage ALU.
- Latches operands from execute, computes over multiple cycles while holding the pipeline via `busy`, then returns the result to be written into the execute output in place of `alu_out`.
- Covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W forms MULW/DIVW/DIVUW/REMW/REMUW.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.
- ITERS, 64, shift-add / restoring-divide iterations per operation.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  abort in-flight op; no response issued.
- req_valid  in  1  execute presents a mul/div op this cycle.
- req_op  in  4  muldiv_op_t opcode.
- req_a  in  XLEN  rs1 value (srca).
- req_b  in  XLEN  rs2 value (srcb).
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready && !flush.
- busy  out  1  stall request to the hazard unit; high in BUSY and DONE.
- resp_valid  out  1  result available; held until resp_ready.
- resp_data  out  XLEN  result, already sign-extended for W ops.
- resp_ready  in  1  execute consumes result this cycle.

Behaviour:
- Reset is asynchronous, active-high. All outputs go to 0 except req_ready=1. State=IDLE; operand, accumulator and counter registers are cleared.
- FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY on accept for a normal op.
  - IDLE→DONE on accept for a special-case op.
  - BUSY→DONE when the counter reaches ITERS-1.
  - DONE→IDLE when resp_ready=1.
  - Any state→IDLE on flush, which has priority over every other transition.
- Latency: request accepted at cycle T.
  - Normal op: 64 iteration cycles T+1..T+64; resp_valid first high at T+65.
  - Special case: resp_valid high at T+1.
- Operand prep at accept:
  - W ops use sign-extended low 32 bits of a/b; DIVUW/REMUW use zero-extended low 32 bits.
  - Signed ops store magnitudes plus a result-sign flag. MULHSU treats b as unsigned.
- Multiply: 128-bit shift-add accumulator, one multiplier bit per cycle.
  - MUL/MULW select product[63:0]; MULH/MULHSU/MULHU select product[127:64].
  - The 128-bit product is two's-complement negated when the sign flag is set.
- Divide: restoring division, one quotient bit per cycle.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases are decided at accept and skip BUSY:
  - b==0: quotient = all ones; remainder = a after W-prep.
  - Signed overflow (DIV: a=0x8000_0000_0000_0000, b=-1; DIVW: a[31:0]=0x8000_0000, b=-1): quotient = a, remainder = 0.
- W result: resp_data = sign-extend(result[31:0]).
- resp_data is registered and holds stable while resp_valid=1 and resp_ready=0.
- No request is accepted in DONE, even in the same cycle as resp_ready. The next accept is possible one cycle after DONE exits.
- Flush in the same cycle as req_valid: request dropped; req_ready stays 1.
- Flush during DONE: resp_valid deasserts next cycle; the result is discarded.
- Reset mid-operation aborts immediately; no response is issued.
- req_a/req_b may change after accept; internal copies are used.

Decomposition:
- The common package gains:
  - muldiv_op_t enum (13 codes, 4 bits).
  - Helper predicates is_div, is_signed_a, is_signed_b, is_word.
  - Control bits extended so decode marks mul/div instructions.
- Sub-module muldiv_step (combinational): one iteration. Inputs: accumulator, operand, mode. Outputs: next accumulator and quotient bit.
- The FSM, counter, sign fixup and special-case logic stay in muldiv_unit.

Test Plan:
- MUL a=7, b=-3 → resp_data=0xFFFF_FFFF_FFFF_FFEB; resp_valid at exactly T+65; busy high T+1..T+65.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULH a=-1, b=-1 → 0. MULHSU a=-1, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV a=-7, b=2 → -3 (0xFFFF_FFFF_FFFF_FFFD); REM same operands → -1. DIVU a=100, b=7 → 14; REMU → 2.
- Specials, each with resp_valid at T+1:
  - DIV a=5, b=0 → 0xFFFF_FFFF_FFFF_FFFF; REM a=5, b=0 → 5.
  - DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000; REM → 0.
  - DIVW a=0x8000_0000, b=-1 → 0xFFFF_FFFF_8000_0000.
- W ops: MULW a=0x7FFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFE. DIVUW a=0xFFFF_FFFF_0000_0010, b=3 → 5.
- Control:
  - flush at T+10 → no resp_valid ever; req_ready=1 at T+11; a new op is then accepted and returns the correct result.
  - resp_ready held low 5 cycles → resp_valid/resp_data stable throughout.
  - Async reset asserted mid-BUSY → outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
// Shared types and helpers for the RV64M multiply/divide engine.
//   muldiv_op_t : 4-bit opcode presented by execute on req_op
//   mdState_t   : engine FSM states
//   mdCtrl_t    : decode control bits marking a mul/div instruction
// Helper predicates classify an opcode so the engine and decode agree.
package muldiv_unit_pkg;

  localparam int WordW = 32;

  typedef enum logic [3:0] {
    MD_MUL    = 4'd0,
    MD_MULH   = 4'd1,
    MD_MULHSU = 4'd2,
    MD_MULHU  = 4'd3,
    MD_DIV    = 4'd4,
    MD_DIVU   = 4'd5,
    MD_REM    = 4'd6,
    MD_REMU   = 4'd7,
    MD_MULW   = 4'd8,
    MD_DIVW   = 4'd9,
    MD_DIVUW  = 4'd10,
    MD_REMW   = 4'd11,
    MD_REMUW  = 4'd12
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_t;

  // Decode output: isMulDiv steers the execute stage to the engine.
  typedef struct packed {
    logic       isMulDiv;
    muldiv_op_t mdOp;
  } mdCtrl_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU,
                      MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return op inside {MD_REM, MD_REMU, MD_REMW, MD_REMUW};
  endfunction

  function automatic logic is_mul_high(input muldiv_op_t op);
    return op inside {MD_MULH, MD_MULHSU, MD_MULHU};
  endfunction

  // MULHSU keeps a signed while b is unsigned; MULW is treated as signed,
  // which leaves the low 32 product bits unaffected.
  function automatic logic is_signed_a(input muldiv_op_t op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM,
                      MD_MULW, MD_DIVW, MD_REMW};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM,
                      MD_MULW, MD_DIVW, MD_REMW};
  endfunction

  function automatic logic is_word(input muldiv_op_t op);
    return op inside {MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
  endfunction

  function automatic logic [63:0] sext32(input logic [WordW-1:0] v);
    return {{(64 - WordW){v[WordW-1]}}, v};
  endfunction

  // Marks OP / OP-32 instructions with funct7=0000001 as mul/div.
  // OP uses funct3 directly as the opcode index (MUL..REMU).
  function automatic mdCtrl_t decode_muldiv(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic [6:0] funct7);
    mdCtrl_t c;
    c.isMulDiv = 1'b0;
    c.mdOp     = MD_MUL;
    if (funct7 == 7'b0000001) begin
      if (opcode == 7'b0110011) begin
        c.isMulDiv = 1'b1;
        c.mdOp     = muldiv_op_t'({1'b0, funct3});
      end else if (opcode == 7'b0111011) begin
        case (funct3)
          3'd0: begin c.isMulDiv = 1'b1; c.mdOp = MD_MULW;  end
          3'd4: begin c.isMulDiv = 1'b1; c.mdOp = MD_DIVW;  end
          3'd5: begin c.isMulDiv = 1'b1; c.mdOp = MD_DIVUW; end
          3'd6: begin c.isMulDiv = 1'b1; c.mdOp = MD_REMW;  end
          3'd7: begin c.isMulDiv = 1'b1; c.mdOp = MD_REMUW; end
          default: c.isMulDiv = 1'b0;
        endcase
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// One combinational iteration of the engine.
//   acc     : 2*XLEN accumulator (mul: {partial, multiplier}; div: {rem, dividend/quotient})
//   operand : multiplicand magnitude (mul) or divisor magnitude (div)
//   isDiv   : selects restoring-divide step instead of shift-add step
//   accNext : accumulator after this iteration (div: bit 0 left clear)
//   qBit    : quotient bit produced by a divide step (0 for multiply)
module muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              isDiv,
  output logic [2*XLEN-1:0] accNext,
  output logic              qBit
);

  logic [XLEN:0] mulSum;
  logic [XLEN:0] divDiff;

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  // Divide: shift the next dividend bit into the remainder and try to
  // subtract; the top bit of the (XLEN+1)-bit difference is the borrow.
  // The quotient bit slot is left clear and filled by the caller from qBit.
  always_comb begin
    mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    divDiff = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, operand};
    qBit    = 1'b0;
    accNext = '0;
    if (isDiv) begin
      qBit    = ~divDiff[XLEN];
      accNext = {(qBit ? divDiff[XLEN-1:0] : {acc[2*XLEN-2:XLEN], acc[XLEN-1]}),
                 acc[XLEN-2:0], 1'b0};
    end else begin
      accNext = {mulSum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV64M multiply/divide engine sitting beside the execute ALU.
//   clk, reset            : clock, asynchronous active-high reset
//   flush                 : abort any in-flight op, no response issued
//   req_valid/op/a/b      : request from execute; req_ready high only in IDLE
//   busy                  : pipeline stall, high while BUSY or DONE
//   resp_valid/resp_data  : registered result, held until resp_ready
// Normal ops iterate ITERS cycles; divide-by-zero and signed overflow are
// resolved at accept and go straight to DONE.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int ITERS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            req_ready,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  input  logic            resp_ready
);

  localparam int CountW = $clog2(ITERS);
  localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MinWord = {{(XLEN-31){1'b1}}, 31'b0};

  mdState_t          state;
  muldiv_op_t        opReg;
  logic [XLEN-1:0]   operandReg;
  logic [2*XLEN-1:0] accReg;
  logic              negReg;
  logic [CountW-1:0] count;

  muldiv_op_t        newOp;
  logic [XLEN-1:0]   aExt;
  logic [XLEN-1:0]   bExt;
  logic              aNeg;
  logic              bNeg;
  logic [XLEN-1:0]   aMag;
  logic [XLEN-1:0]   bMag;
  logic              newNeg;
  logic              divZero;
  logic              divOvf;
  logic              isSpecial;
  logic [XLEN-1:0]   specialRaw;
  logic [XLEN-1:0]   specialData;
  logic [2*XLEN-1:0] initAcc;
  logic [XLEN-1:0]   initOperand;

  logic [2*XLEN-1:0] stepAcc;
  logic              stepQ;
  logic [2*XLEN-1:0] iterAcc;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic [XLEN-1:0]   finalRaw;
  logic [XLEN-1:0]   finalData;

  // Operand preparation for the request currently on the bus. W forms work
  // on the low word (zero-extended for DIVUW/REMUW), signed forms are turned
  // into magnitudes plus one sign flag: quotient/product sign is the xor of
  // the operand signs, remainder sign follows the dividend.
  always_comb begin
    newOp = muldiv_op_t'(req_op);
    if (is_word(newOp)) begin
      aExt = is_signed_a(newOp) ? sext32(req_a[31:0]) : {32'b0, req_a[31:0]};
      bExt = is_signed_b(newOp) ? sext32(req_b[31:0]) : {32'b0, req_b[31:0]};
    end else begin
      aExt = req_a;
      bExt = req_b;
    end
    aNeg   = is_signed_a(newOp) && aExt[XLEN-1];
    bNeg   = is_signed_b(newOp) && bExt[XLEN-1];
    aMag   = aNeg ? -aExt : aExt;
    bMag   = bNeg ? -bExt : bExt;
    newNeg = is_rem(newOp) ? aNeg : (aNeg ^ bNeg);

    initAcc     = is_div(newOp) ? {{XLEN{1'b0}}, aMag} : {{XLEN{1'b0}}, bMag};
    initOperand = is_div(newOp) ? bMag : aMag;
  end

  // Divide special cases are settled at accept so the engine never iterates
  // on them: x/0 gives all ones (remainder = dividend), MIN/-1 gives the
  // dividend back with a zero remainder. W results are re-sign-extended.
  always_comb begin
    divZero = is_div(newOp) && (bExt == '0);
    divOvf  = is_div(newOp) && is_signed_a(newOp) && (bExt == '1) &&
              (aExt == (is_word(newOp) ? MinWord : MinInt));
    isSpecial = divZero || divOvf;
    if (divZero) begin
      specialRaw = is_rem(newOp) ? aExt : '1;
    end else begin
      specialRaw = is_rem(newOp) ? '0 : aExt;
    end
    specialData = is_word(newOp) ? sext32(specialRaw[31:0]) : specialRaw;
  end

  muldiv_step #(.XLEN(XLEN)) uStep (
    .acc     (accReg),
    .operand (operandReg),
    .isDiv   (is_div(opReg)),
    .accNext (stepAcc),
    .qBit    (stepQ)
  );

  // The step leaves the quotient slot clear; insert the new quotient bit
  // for divides. Multiplies use the step result as-is.
  always_comb begin
    iterAcc = is_div(opReg) ? {stepAcc[2*XLEN-1:1], stepQ} : stepAcc;
  end

  // Result assembly from the accumulator produced in the last iteration:
  // apply the stored sign, pick the half / quotient / remainder the op asks
  // for, and sign-extend the low word for W forms.
  always_comb begin
    product   = negReg ? -iterAcc : iterAcc;
    quotient  = negReg ? -iterAcc[XLEN-1:0] : iterAcc[XLEN-1:0];
    remainder = negReg ? -iterAcc[2*XLEN-1:XLEN] : iterAcc[2*XLEN-1:XLEN];
    if (is_div(opReg)) begin
      finalRaw = is_rem(opReg) ? remainder : quotient;
    end else begin
      finalRaw = is_mul_high(opReg) ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
    end
    finalData = is_word(opReg) ? sext32(finalRaw[31:0]) : finalRaw;
  end

  // Control FSM with registered handshake outputs. Flush wins over every
  // other transition and drops any pending result. DONE only returns to
  // IDLE; a request seen in DONE is ignored even while resp_ready is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      opReg      <= MD_MUL;
      operandReg <= '0;
      accReg     <= '0;
      negReg     <= 1'b0;
      count      <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (flush) begin
      state      <= IDLE;
      count      <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            opReg      <= newOp;
            operandReg <= initOperand;
            accReg     <= initAcc;
            negReg     <= newNeg;
            count      <= '0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            if (isSpecial) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_data  <= specialData;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          accReg <= iterAcc;
          count  <= count + CountW'(1);
          if (count == CountW'(ITERS - 1)) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_data  <= finalData;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed bench for muldiv_unit: arithmetic results, latency, special
// cases, flush, response hold and asynchronous reset behaviour.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        req_ready;
  logic        busy;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(64), .ITERS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready)
  );

  // Issue one op, then count cycles after accept until resp_valid (bounded).
  // lat is the cycle offset from accept (T) at which resp_valid is first seen,
  // -1 on timeout. Operands are scrambled after accept.
  task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a,
                               input logic [63:0] b, input bit consume,
                               output logic [63:0] data, output int lat,
                               output bit busyOk);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = 64'hDEAD_BEEF_0BAD_F00D;
    req_b     = 64'h1234_5678_9ABC_DEF0;
    n      = 1;
    busyOk = 1'b1;
    while (resp_valid !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    data = resp_data;
    if (resp_valid === 1'b1) begin
      lat = n;
      if (busy !== 1'b1) busyOk = 1'b0;
      if (consume) begin
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
      end
    end else begin
      lat = -1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, busy, resp_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want 100", {req_ready, busy, resp_valid});
    end
    checks++;
    if (resp_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h want 0", resp_data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_mul();
    muldiv_op_t  ops[5]  = '{MD_MUL, MD_MULHU, MD_MULH, MD_MULHSU, MD_MULW};
    logic [63:0] as[5]   = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_7FFF_FFFF};
    logic [63:0] bs[5]   = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd2};
    logic [63:0] exps[5] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    logic [63:0] data;
    int          lat;
    bit          busyOk;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ops[i], as[i], bs[i], 1'b1, data, lat, busyOk);
      checks++;
      if (data !== exps[i]) begin
        errors++;
        $display("[TB] FAIL mul[%0d] data got %h want %h", i, data, exps[i]);
      end
      checks++;
      if (lat != 65) begin
        errors++;
        $display("[TB] FAIL mul[%0d] latency got %0d want 65", i, lat);
      end
      checks++;
      if (!busyOk) begin
        errors++;
        $display("[TB] FAIL mul[%0d] busy got low want high T+1..T+65", i);
      end
    end
  endtask

  task automatic test_div();
    muldiv_op_t  ops[5]  = '{MD_DIV, MD_REM, MD_DIVU, MD_REMU, MD_DIVUW};
    logic [63:0] as[5]   = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9,
                             64'd100, 64'd100, 64'hFFFF_FFFF_0000_0010};
    logic [63:0] bs[5]   = '{64'd2, 64'd2, 64'd7, 64'd7, 64'd3};
    logic [63:0] exps[5] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'd14, 64'd2, 64'd5};
    logic [63:0] data;
    int          lat;
    bit          busyOk;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ops[i], as[i], bs[i], 1'b1, data, lat, busyOk);
      checks++;
      if (data !== exps[i]) begin
        errors++;
        $display("[TB] FAIL div[%0d] data got %h want %h", i, data, exps[i]);
      end
      checks++;
      if (lat != 65) begin
        errors++;
        $display("[TB] FAIL div[%0d] latency got %0d want 65", i, lat);
      end
    end
  endtask

  task automatic test_special();
    muldiv_op_t  ops[5]  = '{MD_DIV, MD_REM, MD_DIV, MD_REM, MD_DIVW};
    logic [63:0] as[5]   = '{64'd5, 64'd5, 64'h8000_0000_0000_0000,
                             64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000};
    logic [63:0] bs[5]   = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] exps[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000,
                             64'h0, 64'hFFFF_FFFF_8000_0000};
    logic [63:0] data;
    int          lat;
    bit          busyOk;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ops[i], as[i], bs[i], 1'b1, data, lat, busyOk);
      checks++;
      if (data !== exps[i]) begin
        errors++;
        $display("[TB] FAIL special[%0d] data got %h want %h", i, data, exps[i]);
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("[TB] FAIL special[%0d] latency got %0d want 1", i, lat);
      end
    end
  endtask

  task automatic test_flush();
    logic [63:0] data;
    int          lat;
    bit          busyOk;
    bit          sawValid;
    // Flush during BUSY at T+10.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = MD_MUL;
    req_a     = 64'd3;
    req_b     = 64'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL flush_busy_ctrl got %b want 10", {req_ready, busy});
    end
    sawValid = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b0) sawValid = 1'b1;
    end
    checks++;
    if (sawValid) begin
      errors++;
      $display("[TB] FAIL flush_no_resp got resp_valid=1 want 0");
    end
    applyStimulus(MD_DIVU, 64'd100, 64'd7, 1'b1, data, lat, busyOk);
    checks++;
    if (data !== 64'd14 || lat != 65) begin
      errors++;
      $display("[TB] FAIL flush_recover got %h lat %0d want %h lat 65", data, lat, 64'd14);
    end
    // Flush in the same cycle as a request: dropped.
    @(negedge clk);
    req_valid = 1'b1;
    flush     = 1'b1;
    req_op    = MD_DIV;
    req_a     = 64'd5;
    req_b     = 64'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    checks++;
    if ({req_ready, busy, resp_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL flush_same_cycle got %b want 100", {req_ready, busy, resp_valid});
    end
    // Flush while DONE discards the result.
    applyStimulus(MD_DIV, 64'd5, 64'd0, 1'b0, data, lat, busyOk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if ({req_ready, busy, resp_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL flush_done got %b want 100", {req_ready, busy, resp_valid});
    end
  endtask

  task automatic test_hold();
    logic [63:0] data;
    int          lat;
    bit          busyOk;
    bit          stable;
    applyStimulus(MD_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, data, lat, busyOk);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_FFFF_FFEB) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("[TB] FAIL hold_stable got valid=%b data=%h want 1 %h",
               resp_valid, resp_data, 64'hFFFF_FFFF_FFFF_FFEB);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_ready got %b want 0", req_ready);
    end
    // Request alongside resp_ready in DONE must not be accepted.
    req_valid  = 1'b1;
    req_op     = MD_MUL;
    req_a      = 64'd2;
    req_b      = 64'd2;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, busy, resp_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL done_no_accept got %b want 100", {req_ready, busy, resp_valid});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({req_ready, busy, resp_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL done_idle_after got %b want 100", {req_ready, busy, resp_valid});
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] data;
    int          lat;
    bit          busyOk;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = MD_MUL;
    req_a     = 64'd9;
    req_b     = 64'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput: begin
      checks++;
      if ({req_ready, busy, resp_valid} !== 3'b100 || resp_data !== 64'h0) begin
        errors++;
        $display("[TB] FAIL async_reset got %b data %h want 100 data 0",
                 {req_ready, busy, resp_valid}, resp_data);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(MD_MUL, 64'd6, 64'd7, 1'b1, data, lat, busyOk);
    checks++;
    if (data !== 64'd42) begin
      errors++;
      $display("[TB] FAIL post_reset_mul got %h want %h", data, 64'd42);
    end
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 4'd0;
    req_a      = 64'h0;
    req_b      = 64'h0;
    resp_ready = 1'b0;
    $display("[TB] start");
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
